conv3x3_kernel_pipe: RTL and testbench
======================================

Name: conv3x3_kernel_pipe

Overview:
Parametrised 3x3 convolution engine for the image-filter datapath. It takes a 9-pixel window from the line-buffer stage and emits one filtered pixel per accepted window. It adds programmable signed coefficients, selectable shift normalisation with rounding, output saturation, and ready/valid backpressure. Its default reset kernel is a 3x3 Gaussian blur.

Parameters:
PIXEL_W, 8, unsigned pixel width.
COEF_W, 8, signed two's-complement coefficient width.
SHIFT_W, 4, width of the normalisation shift field (shift 0..2^SHIFT_W-1).

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_pixel_data  in  9*PIXEL_W  window; tap k = bits [k*PIXEL_W +: PIXEL_W], k=0..8 row-major, tap 4 = centre.
i_pixel_data_valid  in  1  window valid.
o_pixel_data_ready  out  1  block can accept a window this cycle.
o_convolved_data  out  PIXEL_W  filtered pixel.
o_convolved_data_valid  out  1  output valid.
o_sat  out  1  output was clipped; qualified by o_convolved_data_valid.
i_convolved_data_ready  in  1  downstream accepts output.
i_coef_wr  in  1  shadow-register write strobe.
i_coef_addr  in  4  addresses 0..8 select coefficients k; 9 selects shift (low SHIFT_W bits); 10..15 are ignored.
i_coef_data  in  COEF_W  write data.
i_coef_commit  in  1  copy the shadow bank into the active bank.

Behaviour:
- Reset (i_rst=1 at edge):
  - o_convolved_data=0, o_convolved_data_valid=0, o_sat=0.
  - All stage valids=0.
  - Shadow and active coefficients = {1,2,1,2,4,2,1,2,1}; shadow and active shift = 4.
  - Reset mid-operation discards all in-flight windows. o_pixel_data_ready=1 in the first cycle after reset.
- Handshake:
  - stall = o_convolved_data_valid & ~i_convolved_data_ready.
  - o_pixel_data_ready = ~stall (combinational).
  - A window is accepted when i_pixel_data_valid & o_pixel_data_ready.
  - During stall all three stages hold their contents, and o_convolved_data and o_sat stay stable.
  - Bubbles are not compressed.
- Pipeline (latency 3 cycles, accept edge to output valid, with no stall):
  - S1: p_k = signed(active_coef_k) * zero-extended pixel_k. Product width is COEF_W+PIXEL_W+1. The active shift is captured alongside.
  - S2: sum of the 9 products, sign-extended to COEF_W+PIXEL_W+5 bits. Full adder tree in one stage; no intermediate truncation.
  - S3:
    - r = sum + (shift>0 ? 2^(shift-1) : 0), then arithmetic shift right by shift.
    - If r<0: output 0 and o_sat=1.
    - If r>2^PIXEL_W-1: output 2^PIXEL_W-1 and o_sat=1.
    - Otherwise output r and o_sat=0.
  - Throughput is 1 window per cycle when there is no stall.
- Coefficient bank:
  - i_coef_wr writes the shadow register only. It is legal on any cycle, including during stall.
  - i_coef_commit loads the active bank from the shadow bank at the edge.
  - A window accepted on the same edge as a commit uses the OLD active values.
  - The shift travels with its data, so a commit never alters in-flight windows.
  - If write and commit occur in the same cycle, the write lands in shadow first and the commit copies the pre-write shadow. That write takes effect on the next commit.
- Valid-stage advance: when there is no stall, each stage valid takes the previous stage's valid. The output register updates only when it is empty or its data is being consumed.

Test Plan:
- Reset then stream windows with all taps=16 on consecutive cycles, ready=1 -> output 16 on every cycle starting 3 cycles after the first accept; o_sat=0.
- Load a Laplacian {0,-1,0,-1,4,-1,0,-1,0} with shift 0, then commit.
  - Centre 255, others 0 -> output 255, o_sat=1.
  - Centre 0, others 255 -> output 0, o_sat=1.
- Rounding: kernel with centre=1, others 0, shift=1, commit.
  - Pixel 3 -> 2.
  - Pixel 2 -> 1.
  - Shift 0 with pixel 200 -> 200.
- Backpressure: feed 5 distinct windows while holding i_convolved_data_ready=0 for cycles 4-8.
  - o_pixel_data_ready drops the cycle after output becomes valid.
  - The output holds stable throughout the stall.
  - All 5 results arrive in order, with none lost or duplicated.
- Commit mid-stream: issue commit on the same edge a window is accepted.
  - That window uses the old kernel (Gaussian; 16s -> 16).
  - The next window uses the new kernel.
  - A write in the commit cycle does not take effect until the next commit.
- Assert i_rst while 3 windows are in flight -> no valid output appears afterwards, the coefficients read back as Gaussian (all-16 window -> 16), and o_pixel_data_ready=1.

Source files
------------

// File: rtl/conv3x3_kernel_pipe.sv
// conv3x3_kernel_pipe: 3x3 signed-coefficient convolution with rounding shift, saturation and backpressure.
// Three register stages (products, adder tree, normalise/clip) advance together and all freeze on stall.
module conv3x3_kernel_pipe #(
    parameter int PIXEL_W = 8,
    parameter int COEF_W  = 8,
    parameter int SHIFT_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [9*PIXEL_W-1:0]   i_pixel_data,
    input  logic                   i_pixel_data_valid,
    output logic                   o_pixel_data_ready,
    output logic [PIXEL_W-1:0]     o_convolved_data,
    output logic                   o_convolved_data_valid,
    output logic                   o_sat,
    input  logic                   i_convolved_data_ready,
    input  logic                   i_coef_wr,
    input  logic [3:0]             i_coef_addr,
    input  logic [COEF_W-1:0]      i_coef_data,
    input  logic                   i_coef_commit
);
    localparam int PW = COEF_W + PIXEL_W + 1;
    localparam int SW = COEF_W + PIXEL_W + 5;
    localparam int RW = SW + 1;
    localparam logic signed [RW-1:0] MAX_V = RW'((1 << PIXEL_W) - 1);

    function automatic logic signed [COEF_W-1:0] gauss(input int k);
        return (k == 4) ? COEF_W'(4) : (k % 2 == 1) ? COEF_W'(2) : COEF_W'(1);
    endfunction

    logic signed [COEF_W-1:0] shadow_coef_q [9];
    logic signed [COEF_W-1:0] shadow_coef_d [9];
    logic signed [COEF_W-1:0] active_coef_q [9];
    logic signed [COEF_W-1:0] active_coef_d [9];
    logic [SHIFT_W-1:0]       shadow_shift_q, shadow_shift_d;
    logic [SHIFT_W-1:0]       active_shift_q, active_shift_d;
    logic signed [PW-1:0]     prod_q [9];
    logic signed [PW-1:0]     prod_d [9];
    logic [SHIFT_W-1:0]       s1_shift_q, s1_shift_d;
    logic [SHIFT_W-1:0]       s2_shift_q, s2_shift_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s2_valid_q, s2_valid_d;
    logic signed [SW-1:0]     sum_q, sum_d;
    logic [PIXEL_W-1:0]       out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sat_q, sat_d;
    logic                     stall;
    logic signed [RW-1:0]     rnd, r;

    always_comb begin
        stall = out_valid_q & ~i_convolved_data_ready;
        shadow_coef_d = shadow_coef_q;
        shadow_shift_d = shadow_shift_q;
        active_coef_d = active_coef_q;
        active_shift_d = active_shift_q;
        // commit copies the pre-write shadow because it reads the registered bank
        if (i_coef_commit) begin
            active_coef_d = shadow_coef_q;
            active_shift_d = shadow_shift_q;
        end
        if (i_coef_wr && i_coef_addr < 4'd9)
            shadow_coef_d[i_coef_addr] = i_coef_data;
        if (i_coef_wr && i_coef_addr == 4'd9)
            shadow_shift_d = i_coef_data[SHIFT_W-1:0];
    end

    always_comb begin
        prod_d = prod_q;
        s1_shift_d = s1_shift_q;
        s1_valid_d = s1_valid_q;
        sum_d = sum_q;
        s2_shift_d = s2_shift_q;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_valid_d = out_valid_q;
        sat_d = sat_q;
        rnd = (s2_shift_q != '0) ? (RW'(1) << (s2_shift_q - SHIFT_W'(1))) : '0;
        r = (RW'(sum_q) + rnd) >>> s2_shift_q;
        if (!stall) begin
            for (int k = 0; k < 9; k++)
                prod_d[k] = PW'(active_coef_q[k]) * PW'($signed({1'b0, i_pixel_data[k*PIXEL_W +: PIXEL_W]}));
            s1_shift_d = active_shift_q;
            s1_valid_d = i_pixel_data_valid;
            sum_d = '0;
            for (int k = 0; k < 9; k++)
                sum_d = sum_d + SW'(prod_q[k]);
            s2_shift_d = s1_shift_q;
            s2_valid_d = s1_valid_q;
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = r[RW-1] ? '0 : (r > MAX_V) ? MAX_V[PIXEL_W-1:0] : r[PIXEL_W-1:0];
                sat_d = r[RW-1] | (r > MAX_V);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 9; k++) begin
                shadow_coef_q[k] <= gauss(k);
                active_coef_q[k] <= gauss(k);
                prod_q[k] <= '0;
            end
            shadow_shift_q <= SHIFT_W'(4);
            active_shift_q <= SHIFT_W'(4);
            s1_shift_q <= '0;
            s2_shift_q <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q <= '0;
            out_data_q <= '0;
            out_valid_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            shadow_coef_q <= shadow_coef_d;
            active_coef_q <= active_coef_d;
            prod_q <= prod_d;
            shadow_shift_q <= shadow_shift_d;
            active_shift_q <= active_shift_d;
            s1_shift_q <= s1_shift_d;
            s2_shift_q <= s2_shift_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sum_q <= sum_d;
            out_data_q <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q <= sat_d;
        end
    end

    assign o_pixel_data_ready = ~stall;
    assign o_convolved_data = out_data_q;
    assign o_convolved_data_valid = out_valid_q;
    assign o_sat = sat_q;
endmodule

// File: tb/tb_conv3x3_kernel_pipe.sv
// tb_conv3x3_kernel_pipe: directed stimulus, scoreboard model of the convolution and literal spot checks.
module tb_conv3x3_kernel_pipe;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [71:0] i_pixel_data = '0;
    logic        i_pixel_data_valid = 1'b0;
    logic        o_pixel_data_ready;
    logic [7:0]  o_convolved_data;
    logic        o_convolved_data_valid;
    logic        o_sat;
    logic        i_convolved_data_ready = 1'b1;
    logic        i_coef_wr = 1'b0;
    logic [3:0]  i_coef_addr = '0;
    logic [7:0]  i_coef_data = '0;
    logic        i_coef_commit = 1'b0;

    conv3x3_kernel_pipe dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_pixel_data(i_pixel_data), .i_pixel_data_valid(i_pixel_data_valid),
        .o_pixel_data_ready(o_pixel_data_ready),
        .o_convolved_data(o_convolved_data), .o_convolved_data_valid(o_convolved_data_valid),
        .o_sat(o_sat), .i_convolved_data_ready(i_convolved_data_ready),
        .i_coef_wr(i_coef_wr), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
        .i_coef_commit(i_coef_commit)
    );

    always #5 clk = ~clk;

    typedef struct {int val; bit sat; longint due;} exp_t;
    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     out_cnt = 0;
    longint ptime = 0;
    int     gauss[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int     lap[9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    int     ctr[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int     m_act[9], m_shd[9];
    int     m_sh_act = 4, m_sh_shd = 4;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    function automatic void calc(input logic [71:0] pix, input int c[9], input int sh,
                                 output int val, output bit sat);
        int s = 0;
        for (int k = 0; k < 9; k++) s += c[k] * int'(pix[k*8 +: 8]);
        s = (s + (sh > 0 ? (1 << (sh - 1)) : 0)) >>> sh;
        sat = (s < 0) || (s > 255);
        val = (s < 0) ? 0 : (s > 255) ? 255 : s;
    endfunction

    function automatic logic [71:0] win(input int c, input int o);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = (k == 4) ? c[7:0] : o[7:0];
        return w;
    endfunction

    // scoreboard: pipeline time advances only on non-stalled edges, so each window is due 3 ticks later
    always @(negedge clk) begin
        bit exp_v, stall_m, s;
        int v;
        if (i_rst) begin
            q.delete();
            m_act = gauss;
            m_shd = gauss;
            m_sh_act = 4;
            m_sh_shd = 4;
        end else begin
            exp_v = (q.size() > 0) && (q[0].due <= ptime);
            chk("out_valid", o_convolved_data_valid, exp_v);
            chk("in_ready", o_pixel_data_ready, !(exp_v && !i_convolved_data_ready));
            if (exp_v && o_convolved_data_valid) begin
                chk("out_data", o_convolved_data, q[0].val);
                chk("out_sat", o_sat, q[0].sat);
            end
            stall_m = exp_v && !i_convolved_data_ready;
            if (exp_v && i_convolved_data_ready) begin
                void'(q.pop_front());
                out_cnt++;
            end
            if (i_pixel_data_valid && !stall_m) begin
                calc(i_pixel_data, m_act, m_sh_act, v, s);
                q.push_back('{val: v, sat: s, due: ptime + 3});
            end
            if (!stall_m) ptime++;
            if (i_coef_commit) begin
                m_act = m_shd;
                m_sh_act = m_sh_shd;
            end
            if (i_coef_wr && i_coef_addr < 9) m_shd[i_coef_addr] = int'($signed(i_coef_data));
            if (i_coef_wr && i_coef_addr == 9) m_sh_shd = int'(i_coef_data[3:0]);
        end
    end

    task automatic send(input logic [71:0] pix);
        int g = 0;
        i_pixel_data = pix;
        i_pixel_data_valid = 1'b1;
        @(negedge clk);
        while (!o_pixel_data_ready && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        i_pixel_data_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input int d);
        i_coef_wr = 1'b1; i_coef_addr = a; i_coef_data = d[7:0];
        @(posedge clk); #1;
        i_coef_wr = 1'b0;
    endtask

    task automatic commit();
        i_coef_commit = 1'b1;
        @(posedge clk); #1;
        i_coef_commit = 1'b0;
    endtask

    task automatic load(input int c[9], input int sh);
        for (int k = 0; k < 9; k++) wr(4'(k), c[k]);
        wr(4'd9, sh);
        commit();
    endtask

    task automatic expect_out(input string nm, input int ev, input bit es);
        int g = 0;
        @(negedge clk);
        while (!o_convolved_data_valid && g < 20) begin @(negedge clk); g++; end
        if (!o_convolved_data_valid) chk({nm, "_timeout"}, 0, 1);
        else begin
            chk(nm, o_convolved_data, ev);
            chk({nm, "_sat"}, o_sat, es);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        bit s;
        int base;
        logic [7:0] held;
        calc(win(16, 16), gauss, 4, v, s);
        chk("model_gauss", v, 16);
        calc(win(255, 0), lap, 0, v, s);
        chk("model_lap_hi", {v[30:0], s}, {31'd255, 1'b1});
        calc(win(3, 9), ctr, 1, v, s);
        chk("model_round", v, 2);

        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", o_convolved_data_valid, 0);
        chk("rst_data", o_convolved_data, 0);
        chk("rst_sat", o_sat, 0);
        chk("rst_ready", o_pixel_data_ready, 1);
        @(posedge clk); #1;

        send(win(16, 16));
        @(negedge clk); chk("lat_c1", o_convolved_data_valid, 0);
        @(negedge clk); chk("lat_c2", o_convolved_data_valid, 0);
        @(negedge clk); chk("lat_c3", o_convolved_data_valid, 1);
        chk("lat_data", o_convolved_data, 16);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send(win(16, 16));
        idle(5);

        for (int k = 0; k < 9; k++) wr(4'(k), lap[k]);
        wr(4'd9, 0);
        i_coef_commit = 1'b1; i_coef_wr = 1'b1; i_coef_addr = 4'd4; i_coef_data = 8'd2;
        send(win(16, 16));
        i_coef_commit = 1'b0; i_coef_wr = 1'b0;
        expect_out("commit_old", 16, 0);
        send(win(50, 16));
        expect_out("commit_new", 136, 0);
        commit();
        send(win(50, 16));
        expect_out("late_write", 36, 0);
        wr(4'd4, 4);
        commit();

        send(win(255, 0));
        expect_out("lap_hi", 255, 1);
        send(win(0, 255));
        expect_out("lap_lo", 0, 1);

        load(ctr, 1);
        send(win(3, 77));
        expect_out("round_3", 2, 0);
        send(win(2, 77));
        expect_out("round_2", 1, 0);
        wr(4'd9, 0);
        wr(4'd10, 7);
        commit();
        send(win(200, 0));
        expect_out("shift0", 200, 0);
        idle(3);

        base = out_cnt;
        fork
            for (int i = 1; i <= 5; i++) send(win(10 * i, 3));
            begin
                repeat (3) @(posedge clk);
                #1 i_convolved_data_ready = 1'b0;
                @(negedge clk);
                chk("bp_ready_low", o_pixel_data_ready, 0);
                chk("bp_first", o_convolved_data, 10);
                held = o_convolved_data;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_hold", o_convolved_data, held);
                end
                @(posedge clk); #1 i_convolved_data_ready = 1'b1;
            end
        join
        idle(8);
        chk("bp_count", out_cnt - base, 5);
        chk("bp_drained", q.size(), 0);

        for (int i = 0; i < 3; i++) send(win(100, 100));
        i_rst = 1'b1;
        @(posedge clk); #1 i_rst = 1'b0;
        @(negedge clk);
        chk("rst2_ready", o_pixel_data_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk("rst2_novalid", o_convolved_data_valid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send(win(16, 16));
        expect_out("rst2_gauss", 16, 0);
        idle(4);
        chk("final_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
